// File: rtl/yarvi_me_if.sv
`default_nettype none
// ============================================================================
// Module      : yarvi_me_if
// Description : EX -> ME request bundle. Carries the EX slot and its
//               load/store request into the memory stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface yarvi_me_if #(
    parameter int XLEN = 32,
    parameter int VLEN = 32
);
    logic            valid;
    logic [VLEN-1:0] pc;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_val;
    logic            readenable;
    logic            writeenable;
    logic [2:0]      funct3;
    logic [XLEN-1:0] writedata;

    modport master (
        output valid, pc, wb_rd, wb_val, readenable, writeenable, funct3, writedata
    );

    modport slave (
        input  valid, pc, wb_rd, wb_val, readenable, writeenable, funct3, writedata
    );
endinterface
`default_nettype wire

// File: rtl/yarvi_me.sv
`default_nettype none
// ============================================================================
// Module      : yarvi_me
// Description : YARVI2 memory stage. Data RAM (read at the EX->ME edge,
//               stores committed from ME one cycle later), 64-bit machine
//               timer with registered interrupt, misalignment detection and
//               load-hit-store restart signalling.
// Revision    : 1.0 - initial release
// ============================================================================
module yarvi_me #(
    parameter int              XLEN       = 32,
    parameter int              VLEN       = 32,
    parameter int              DMEM_LOG2  = 12,
    parameter logic [XLEN-1:0] DMEM_BASE  = 32'h4000_0000,
    parameter logic [XLEN-1:0] TIMER_BASE = 32'h8000_0000
) (
    input  logic            clock,
    input  logic            reset,
    yarvi_me_if.slave       ex,
    output logic            me_valid,
    output logic [VLEN-1:0] me_pc,
    output logic [4:0]      me_wb_rd,
    output logic [XLEN-1:0] me_wb_val,
    output logic            me_exc_misaligned,
    output logic [XLEN-1:0] me_exc_mtval,
    output logic            me_load_hit_store,
    output logic            me_timer_interrupt
);
    localparam int XMSB = XLEN - 1;
    localparam int VMSB = VLEN - 1;
    localparam int WORD_HI = XMSB - 2;

    // ---------------------------------------------------------------- state
    logic [31:0]    dmem [0:(1 << DMEM_LOG2) - 1];
    logic [31:0]    ram_q;
    logic [31:0]    timer_q;
    logic           ld_ram_r, ld_timer_r;

    logic [VMSB:0]  pc_r;
    logic           valid_r;
    logic [4:0]     rd_r;
    logic [XMSB:0]  alu_r;
    logic           ld_r, st_r;
    logic           misal_r;
    logic [XMSB:0]  mtval_r;
    logic [2:0]     f3_r;
    logic [WORD_HI:0] acc_word;
    logic [1:0]     acc_off;
    logic [3:0]     acc_mask;
    logic [31:0]    st_data;
    logic           pend, pend_ram;

    logic           prev_commit;
    logic [WORD_HI:0] prev_word;
    logic [3:0]     prev_mask;

    logic [63:0]    mtime, mtimecmp;
    logic           irq_r;

    // ------------------------------------------------------- EX-side decode
    logic [XMSB:0]  addr;
    logic           is_load, is_store, misal, in_ram, in_timer;
    logic [1:0]     size;
    logic [3:0]     mask;
    logic [31:0]    wdata_rep;
    logic [31:0]    timer_rd;

    // Classify the EX request: kind, alignment, target region, lanes and data
    always_comb begin
        addr      = ex.wb_val;
        size      = ex.funct3[1:0];
        is_store  = ex.valid & ex.writeenable;
        is_load   = ex.valid & ex.readenable & ~ex.writeenable;
        misal     = (is_load | is_store) &
                    (((size == 2'd1) & addr[0]) | (size[1] & (addr[1:0] != 2'b00)));
        in_ram    = (addr[XMSB:DMEM_LOG2+2] == DMEM_BASE[XMSB:DMEM_LOG2+2]);
        in_timer  = (addr[XMSB:4] == TIMER_BASE[XMSB:4]);
        mask      = 4'b1111;
        wdata_rep = ex.writedata[31:0];
        case (size)
            2'd0: begin
                mask      = 4'b0001 << addr[1:0];
                wdata_rep = {4{ex.writedata[7:0]}};
            end
            2'd1: begin
                mask      = addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{ex.writedata[15:0]}};
            end
            default: ;
        endcase
        case (addr[3:2])
            2'd0:    timer_rd = mtime[31:0];
            2'd1:    timer_rd = mtime[63:32];
            2'd2:    timer_rd = mtimecmp[31:0];
            default: timer_rd = mtimecmp[63:32];
        endcase
    end

    // EX->ME pipeline register plus the history of the store that just left ME
    always_ff @(posedge clock) begin
        if (!reset) begin
            valid_r     <= 1'b0;
            pc_r        <= '0;
            rd_r        <= '0;
            alu_r       <= '0;
            ld_r        <= 1'b0;
            st_r        <= 1'b0;
            misal_r     <= 1'b0;
            mtval_r     <= '0;
            f3_r        <= '0;
            acc_word    <= '0;
            acc_off     <= '0;
            acc_mask    <= '0;
            st_data     <= '0;
            pend        <= 1'b0;
            pend_ram    <= 1'b0;
            ld_ram_r    <= 1'b0;
            ld_timer_r  <= 1'b0;
            timer_q     <= '0;
            prev_commit <= 1'b0;
            prev_word   <= '0;
            prev_mask   <= '0;
        end else begin
            valid_r     <= ex.valid;
            pc_r        <= ex.pc;
            rd_r        <= ex.valid ? ex.wb_rd : 5'd0;
            alu_r       <= ex.wb_val;
            ld_r        <= is_load & ~misal;
            st_r        <= is_store;
            misal_r     <= misal;
            mtval_r     <= misal ? addr : '0;
            f3_r        <= ex.funct3;
            acc_word    <= addr[XMSB:2];
            acc_off     <= addr[1:0];
            acc_mask    <= mask;
            st_data     <= wdata_rep;
            pend        <= is_store & ~misal & (in_ram | in_timer);
            pend_ram    <= in_ram;
            ld_ram_r    <= in_ram;
            ld_timer_r  <= in_timer;
            timer_q     <= timer_rd;
            prev_commit <= pend;
            prev_word   <= acc_word;
            prev_mask   <= acc_mask;
        end
    end

    // Read-first data RAM: commit the ME store and read for the EX load together
    always_ff @(posedge clock) begin
        if (reset && pend && pend_ram) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_mask[i]) begin
                    dmem[acc_word[DMEM_LOG2-1:0]][8*i +: 8] <= st_data[8*i +: 8];
                end
            end
        end
        ram_q <= dmem[addr[DMEM_LOG2+1:2]];
    end

    // ------------------------------------------------------------- timer
    logic [31:0] byte_mask;
    logic [63:0] mtime_nxt, mtimecmp_nxt;
    logic        tmr_wr;

    // Next timer values: a store to a half replaces it and freezes the other half
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            byte_mask[8*i +: 8] = {8{acc_mask[i]}};
        end
        tmr_wr       = pend & ~pend_ram;
        mtime_nxt    = mtime + 64'd1;
        mtimecmp_nxt = mtimecmp;
        if (tmr_wr) begin
            case (acc_word[1:0])
                2'd0: mtime_nxt = {mtime[63:32],
                                   (mtime[31:0] & ~byte_mask) | (st_data & byte_mask)};
                2'd1: mtime_nxt = {(mtime[63:32] & ~byte_mask) | (st_data & byte_mask),
                                   mtime[31:0]};
                2'd2: mtimecmp_nxt[31:0]  = (mtimecmp[31:0] & ~byte_mask) | (st_data & byte_mask);
                default: mtimecmp_nxt[63:32] = (mtimecmp[63:32] & ~byte_mask) | (st_data & byte_mask);
            endcase
        end
    end

    // Timer registers and interrupt, compared on the post-update values
    always_ff @(posedge clock) begin
        if (!reset) begin
            mtime    <= '0;
            mtimecmp <= '1;
            irq_r    <= 1'b0;
        end else begin
            mtime    <= mtime_nxt;
            mtimecmp <= mtimecmp_nxt;
            irq_r    <= (mtime_nxt >= mtimecmp_nxt);
        end
    end

    // --------------------------------------------------------- ME outputs
    logic [31:0] load_word, shifted, load_val;
    logic        lhs;

    // Lane-select and extend the loaded word; detect a load racing the last store
    always_comb begin
        load_word = ld_ram_r ? ram_q : (ld_timer_r ? timer_q : 32'd0);
        shifted   = load_word >> {acc_off, 3'b000};
        case (f3_r)
            3'd0:    load_val = {{24{shifted[7]}}, shifted[7:0]};
            3'd1:    load_val = {{16{shifted[15]}}, shifted[15:0]};
            3'd4:    load_val = {24'd0, shifted[7:0]};
            3'd5:    load_val = {16'd0, shifted[15:0]};
            default: load_val = load_word;
        endcase
        lhs = ld_r & prev_commit & (prev_word == acc_word) & (|(prev_mask & acc_mask));
    end

    assign me_valid           = valid_r;
    assign me_pc              = pc_r;
    assign me_wb_val          = ld_r ? load_val : alu_r;
    assign me_wb_rd           = (st_r | misal_r | lhs) ? 5'd0 : rd_r;
    assign me_exc_misaligned  = misal_r;
    assign me_exc_mtval       = mtval_r;
    assign me_load_hit_store  = lhs;
    assign me_timer_interrupt = irq_r;
endmodule
`default_nettype wire
